seq_alu_exec: RTL and testbench
===============================

# seq_alu_exec

Multi-cycle execute unit that consumes the 4-bit `alu_ctrl` code from ALU control, together with the two 32-bit operands, and produces a registered result through a valid/ready handshake. Logical, arithmetic and compare operations complete in one cycle. Shifts are performed iteratively, one bit position per cycle, trading latency for area. The unit sits between decode/operand-select and writeback in the area-reduced multi-cycle core variant.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: unit can accept a request; equals (state==IDLE).
- `alu_ctrl` input 4: operation code. 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA. 1010–1111 execute as ADD.
- `op_a` input 32: operand A; the shifted value for shifts.
- `op_b` input 32: operand B; shifts use only `op_b[4:0]` as shamt.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output 32: registered result.
- `zero` output 1: (result==0), derived from the `result` register.
- `busy` output 1: high in SHIFT state.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Acceptance: an `in_valid && in_ready` at a rising edge captures `alu_ctrl`, `op_a` and shamt.
- IDLE, non-shift, or shift with shamt==0:
  - Compute the result combinationally from the inputs; for a zero-shamt shift the result is `op_a`.
  - Register the result and go to DONE.
- IDLE, shift with shamt k≥1:
  - Load acc=`op_a` and cnt=k; go to SHIFT.
- SHIFT, each cycle:
  - SLL: acc<<1.
  - SRL: acc>>1 with zero fill.
  - SRA: acc>>1 with acc[31] replicated.
  - cnt decrements each cycle. On the cycle where cnt==1, write the shifted value to `result` and go to DONE.
- DONE: `out_valid`=1; `result`/`zero` are held stable. On `out_ready` go to IDLE. `in_valid` is ignored outside IDLE.
- Arithmetic: ADD/SUB wrap modulo 2^32, with no overflow flag. SLT is a signed compare; SLTU is unsigned. Both return 32'h0/32'h1.
- Asynchronous reset at any time, including mid-shift or in DONE with a pending result:
  - State goes to IDLE and the operation is discarded.
  - `result`=0, `zero`=1, `out_valid`=0, `busy`=0, `in_ready`=1.
  - No result for the aborted operation is ever presented.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=32'h0, `zero`=1.
- Non-shift, or shift with shamt 0, accepted at edge N: `out_valid` is high from edge N (latency 1).
- Shift with shamt k≥1, accepted at edge N:
  - `busy` is high from edge N to edge N+k.
  - `out_valid` is high from edge N+k (latency k+1, maximum 32).
- A result accepted (`out_ready`=1) at edge M returns the unit to IDLE. `in_ready`=1 after M, so the next request can be accepted at edge M+1.
- Sustained throughput for single-cycle ops is therefore one operation per 2 cycles.
- `in_ready` is combinational from state only, with no path from `in_valid`.
- `out_valid`, `result` and `zero` are registered, with no combinational path from inputs.
- `out_valid` never deasserts without a handshake unless reset is asserted.

## Test plan
- Basic ADD: ADD with `op_a`=5, `op_b`=7, accepted at edge N, `out_ready`=1 → `result`=12, `zero`=0, `out_valid` high exactly one cycle; `in_ready` returns 1 the following cycle.
- SUB and compares:
  - SUB 3−3 → `result`=0, `zero`=1.
  - SLT with `op_a`=32'hFFFFFFFF, `op_b`=1 → 1.
  - SLTU with the same operands → 0.
  - Code 1111 with 2+2 → 4.
- Max shift: SRA with `op_a`=32'h80000000, `op_b`=31 → `busy` high for 31 cycles, `out_valid` after 32 cycles total, `result`=32'hFFFFFFFF.
  - Same operands with SRL → 32'h00000001.
  - SLL with `op_a`=1, `op_b`=32'h00000024 (shamt 4) → 32'h10 after 5 cycles.
  - SLL with shamt 0 and `op_a`=32'hDEADBEEF → 32'hDEADBEEF in 1 cycle.
- Backpressure: `out_ready` low for 5 cycles → `result`/`out_valid` stable throughout. `in_ready`=0 and a new `in_valid` is ignored; the operation completes only after `out_ready` rises.
- Reset mid-shift: assert `rst_n`=0 during an SLL shamt 20, at cycle 10 → outputs immediately reach reset values. After release no `out_valid` occurs until a new request; a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/seq_alu_exec.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare ops, iterative
// one-bit-per-cycle shifts, registered result behind a valid/ready handshake.
module seq_alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                           OP_SRL = 4'd8, OP_SRA = 4'd9;

    state_t          r_state, w_next;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_acc, r_result;
    logic [4:0]      r_cnt;

    logic            w_accept, w_is_shift, w_multi;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu, w_shifted;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state == SHIFT);
    assign result     = r_result;
    assign zero       = (r_result == '0);

    assign w_shamt    = op_b[4:0];
    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign w_multi    = w_is_shift && (w_shamt != 5'd0);

    // Shift codes fall through to op_a: that is the zero-shamt result.
    always_comb begin
        w_alu = op_a + op_b;
        case (alu_ctrl)
            OP_SUB:  w_alu = op_a - op_b;
            OP_AND:  w_alu = op_a & op_b;
            OP_OR:   w_alu = op_a | op_b;
            OP_XOR:  w_alu = op_a ^ op_b;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_SLL, OP_SRL, OP_SRA: w_alu = op_a;
            default: w_alu = op_a + op_b;
        endcase
    end

    always_comb begin
        w_shifted = {r_acc[XLEN-2:0], 1'b0};
        case (r_op)
            OP_SRL:  w_shifted = {1'b0, r_acc[XLEN-1:1]};
            OP_SRA:  w_shifted = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_shifted = {r_acc[XLEN-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_multi ? SHIFT : DONE;
            SHIFT:   if (r_cnt == 5'd1) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= alu_ctrl;
            r_acc <= op_a;
            r_cnt <= w_shamt;
            if (!w_multi) r_result <= w_alu;
        end else if (r_state == SHIFT) begin
            r_acc <= w_shifted;
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) r_result <= w_shifted;
        end
    end
endmodule

// File: tb/tb_seq_alu_exec.sv
// Directed bench for seq_alu_exec: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on each output handshake.
module tb_seq_alu_exec;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b, result;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    seq_alu_exec #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got result %h expected no output", result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("result", result, e);
                chk("zero", {31'b0, zero}, {31'b0, (e == 32'h0)});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issue one op with out_ready=1; checks latency, busy length and the
    // single-cycle out_valid pulse.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n = 0;
        int nb = 0;
        wait_idle();
        exp_q.push_back(exp);
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            if (busy) nb++;
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, n + 1, lat);
        chk({name, "_busy_cycles"}, nb, lat - 1);
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int nv;
        rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 4'd0; op_a = '0; op_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add",    4'b0000, 32'd5,        32'd7,        32'd12,       1);
        run_op("sub0",   4'b0001, 32'd3,        32'd3,        32'd0,        1);
        run_op("subwr",  4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 1);
        run_op("and",    4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        run_op("or",     4'b0011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1);
        run_op("xor",    4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
        run_op("slt",    4'b0101, 32'hFFFFFFFF, 32'd1,        32'd1,        1);
        run_op("sltu",   4'b0110, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
        run_op("op1111", 4'b1111, 32'd2,        32'd2,        32'd4,        1);
        run_op("sra31",  4'b1001, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32);
        run_op("srl31",  4'b1000, 32'h80000000, 32'd31,       32'h00000001, 32);
        run_op("sll4",   4'b0111, 32'd1,        32'h00000024, 32'h00000010, 5);
        run_op("sll0",   4'b0111, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1);

        // Backpressure: hold the result 5 cycles while poking in_valid.
        wait_idle();
        out_ready = 1'b0;
        exp_q.push_back(32'h00000300);
        in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'h100; op_b = 32'h200;
        @(posedge clk); #1;
        alu_ctrl = 4'b0001; op_a = 32'h55; op_b = 32'h11;
        held = result;
        chk("bp_first_result", held, 32'h00000300);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, held);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'b0, out_valid}, 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("bp_no_extra", {31'b0, out_valid}, 32'd0);

        // Reset mid-shift: SLL shamt 20 aborted after 10 cycles.
        wait_idle();
        in_valid = 1'b1; alu_ctrl = 4'b0111; op_a = 32'h3; op_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_result", result, 32'h0);
        chk("mrst_zero", {31'b0, zero}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("post_rst_no_valid", nv, 0);
        run_op("add_after_rst", 4'b0000, 32'd1, 32'd1, 32'd2, 1);

        repeat (2) @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
